// File: rtl/serial_stim_pkg.sv
// Shared types and default sizing for the serial stimulus transmitter.
package serial_stim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } tx_state_t;

    localparam int unsigned DefaultWidth     = 8;
    localparam int unsigned DefaultGapCycles = 1;
    localparam int unsigned DefaultRepW      = 4;

endpackage

// File: rtl/serial_shift_reg.sv
// Load/shift-left register feeding the serial line; a load left-aligns bit nbits-1 onto the MSB.
module serial_shift_reg
    import serial_stim_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned NW    = $clog2(DefaultWidth + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [NW-1:0]    nbits,
    input  logic [WIDTH-1:0] data,
    output logic             msb_next
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = data << (NW'(WIDTH) - nbits);
        end else if (shift) begin
            sr_d = sr_q << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    // MSB as it will stand after this edge, so the owner can register x_out directly.
    assign msb_next = sr_d[WIDTH-1];

endmodule

// File: rtl/serial_stim_tx.sv
// Serial bit-stream source: shifts a captured word out MSB-first, repeating it with idle gaps.
module serial_stim_tx
    import serial_stim_pkg::*;
#(
    parameter int unsigned WIDTH      = DefaultWidth,
    parameter int unsigned GAP_CYCLES = DefaultGapCycles,
    parameter int unsigned REP_W      = DefaultRepW
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [WIDTH-1:0]             data_in,
    input  logic [$clog2(WIDTH+1)-1:0]   nbits_in,
    input  logic [REP_W-1:0]             repeat_in,
    input  logic                         abort,
    output logic                         x_out,
    output logic                         x_valid,
    output logic                         busy,
    output logic                         done,
    output logic [1:0]                   state_out
);

    localparam int unsigned NW      = $clog2(WIDTH + 1);
    localparam int unsigned BW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned GW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GapLoad = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    tx_state_t        state;
    logic [WIDTH-1:0] word_q;
    logic [NW-1:0]    nbits_q;
    logic [BW-1:0]    bit_idx;
    logic [REP_W-1:0] frames_left;
    logic [GW-1:0]    gap_cnt;
    logic             x_out_q, x_valid_q, done_q;

    logic [NW-1:0]    eff_nbits;
    logic [REP_W-1:0] eff_repeat;
    logic             handshake, restart_now, gap_end;
    logic             sr_load, sr_shift, msb_next;
    logic [WIDTH-1:0] sr_data;
    logic [NW-1:0]    sr_nbits;

    assign eff_nbits  = (nbits_in == '0 || nbits_in > NW'(WIDTH)) ? NW'(WIDTH) : nbits_in;
    assign eff_repeat = (repeat_in == '0) ? REP_W'(1) : repeat_in;

    assign handshake   = (state == IDLE) && load_valid && !abort;
    assign restart_now = (state == SHIFT) && (bit_idx == '0) && (frames_left > REP_W'(1))
                         && (GAP_CYCLES == 0);
    assign gap_end     = (state == GAP) && (gap_cnt == '0);

    assign sr_load  = handshake || restart_now || gap_end;
    assign sr_shift = (state == SHIFT) && (bit_idx != '0);
    assign sr_data  = (state == IDLE) ? data_in : word_q;
    assign sr_nbits = (state == IDLE) ? eff_nbits : nbits_q;

    serial_shift_reg #(
        .WIDTH (WIDTH),
        .NW    (NW)
    ) u_shift_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (sr_load),
        .shift    (sr_shift),
        .nbits    (sr_nbits),
        .data     (sr_data),
        .msb_next (msb_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            word_q      <= '0;
            nbits_q     <= '0;
            bit_idx     <= '0;
            frames_left <= '0;
            gap_cnt     <= '0;
            x_out_q     <= 1'b0;
            x_valid_q   <= 1'b0;
            done_q      <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            x_out_q   <= 1'b0;
            x_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            x_out_q   <= 1'b0;
            x_valid_q <= 1'b0;
            done_q    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load_valid) begin
                        word_q      <= data_in;
                        nbits_q     <= eff_nbits;
                        frames_left <= eff_repeat;
                        bit_idx     <= BW'(eff_nbits - NW'(1));
                        state       <= SHIFT;
                        x_valid_q   <= 1'b1;
                        x_out_q     <= msb_next;
                    end
                end
                SHIFT: begin
                    if (bit_idx != '0) begin
                        bit_idx   <= bit_idx - BW'(1);
                        x_valid_q <= 1'b1;
                        x_out_q   <= msb_next;
                    end else if (frames_left > REP_W'(1)) begin
                        frames_left <= frames_left - REP_W'(1);
                        if (GAP_CYCLES > 0) begin
                            state   <= GAP;
                            gap_cnt <= GW'(GapLoad);
                        end else begin
                            bit_idx   <= BW'(nbits_q - NW'(1));
                            x_valid_q <= 1'b1;
                            x_out_q   <= msb_next;
                        end
                    end else begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state     <= SHIFT;
                        bit_idx   <= BW'(nbits_q - NW'(1));
                        x_valid_q <= 1'b1;
                        x_out_q   <= msb_next;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign x_out      = x_out_q;
    assign x_valid    = x_valid_q;
    assign done       = done_q;
    assign load_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign state_out  = state;

endmodule

// File: tb/tb_serial_stim_tx.sv
// Bench for serial_stim_tx: table-driven frames, corner sequences and randomized frames vs a stream model.
module tb_serial_stim_tx;

    localparam int W    = 8;
    localparam int GAPC = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_valid = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] data_in = '0;
    logic [3:0] nbits_in = '0;
    logic [3:0] repeat_in = '0;
    logic       load_ready, x_out, x_valid, busy, done;
    logic [1:0] state_out;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    serial_stim_tx #(
        .WIDTH      (W),
        .GAP_CYCLES (GAPC),
        .REP_W      (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .data_in    (data_in),
        .nbits_in   (nbits_in),
        .repeat_in  (repeat_in),
        .abort      (abort),
        .x_out      (x_out),
        .x_valid    (x_valid),
        .busy       (busy),
        .done       (done),
        .state_out  (state_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One entry per cycle after the handshake: valid, bit, done.
    typedef struct packed {logic v; logic x; logic d;} cyc_t;
    cyc_t exp_q[$];

    task automatic build_model(input logic [7:0] d, input int n, input int r);
        int en, er;
        en = (n == 0 || n > W) ? W : n;
        er = (r == 0) ? 1 : r;
        exp_q.delete();
        for (int f = 0; f < er; f++) begin
            for (int i = en - 1; i >= 0; i--) exp_q.push_back({1'b1, d[i], 1'b0});
            if (f < er - 1)
                for (int g = 0; g < GAPC; g++) exp_q.push_back({1'b0, 1'b0, 1'b0});
        end
        exp_q.push_back({1'b0, 1'b0, 1'b1});
    endtask

    task automatic run_frame(input logic [7:0] d, input int n, input int r, input bit noise,
                             output int nvalid, output int done_cyc);
        int waited;
        waited   = 0;
        nvalid   = 0;
        done_cyc = -1;
        while (load_ready !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        check("ready_before_load", {31'd0, load_ready}, 32'd1);
        if (load_ready !== 1'b1) return;
        build_model(d, n, r);
        data_in    = d;
        nbits_in   = n[3:0];
        repeat_in  = r[3:0];
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) begin
                if (noise) begin
                    load_valid = 1'($urandom_range(0, 1));
                    data_in    = 8'($urandom);
                    nbits_in   = 4'($urandom);
                    repeat_in  = 4'($urandom);
                end
                step();
            end
            check($sformatf("stream d=%0h n=%0d r=%0d c%0d", d, n, r, i + 1),
                  {28'd0, x_valid, x_out, done, busy},
                  {28'd0, exp_q[i].v, exp_q[i].x, exp_q[i].d, 1'b1});
            if (x_valid === 1'b1) nvalid++;
            if (done === 1'b1 && done_cyc < 0) done_cyc = i + 1;
        end
        load_valid = 1'b0;
        step();
        check("ready_after_done", {28'd0, load_ready, busy, done, x_valid}, 32'b1000);
    endtask

    typedef struct {
        logic [7:0] data;
        int         nbits;
        int         rep;
        int         exp_nvalid;
        int         exp_done;
    } vec_t;

    vec_t vecs[8];
    int   nv, dc;

    initial begin
        vecs[0] = '{8'hB2, 8, 1, 8, 9};
        vecs[1] = '{8'hF5, 3, 2, 6, 8};
        vecs[2] = '{8'h81, 0, 1, 8, 9};
        vecs[3] = '{8'h81, 12, 1, 8, 9};
        vecs[4] = '{8'h81, 8, 0, 8, 9};
        vecs[5] = '{8'h01, 1, 1, 1, 2};
        vecs[6] = '{8'hA5, 4, 3, 12, 15};
        vecs[7] = '{8'h3C, 5, 4, 20, 24};

        // Reset held with a pending request: nothing may be captured.
        reset      = 1'b0;
        load_valid = 1'b1;
        data_in    = 8'hFF;
        nbits_in   = 4'd8;
        repeat_in  = 4'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_outputs", {26'd0, x_out, x_valid, done, busy, state_out}, 32'd0);
        end
        reset      = 1'b1;
        load_valid = 1'b0;
        step();
        check("ready_after_reset", {27'd0, load_ready, busy, x_valid, state_out}, 32'b10000);

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].data, vecs[i].nbits, vecs[i].rep, 1'b0, nv, dc);
            check($sformatf("tbl_nvalid[%0d]", i), nv, vecs[i].exp_nvalid);
            check($sformatf("tbl_done_cycle[%0d]", i), dc, vecs[i].exp_done);
        end

        // Abort on the 4th bit, with a stray load_valid during SHIFT.
        data_in    = 8'hB2;
        nbits_in   = 4'd8;
        repeat_in  = 4'd1;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        check("abort_b1", {30'd0, x_valid, x_out}, 32'b11);
        data_in    = 8'h00;
        nbits_in   = 4'd1;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        check("abort_b2", {30'd0, x_valid, x_out}, 32'b10);
        step();
        check("abort_b3", {30'd0, x_valid, x_out}, 32'b11);
        step();
        check("abort_b4", {30'd0, x_valid, x_out}, 32'b11);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_to_idle", {27'd0, x_valid, done, busy, state_out}, 32'd0);
        step();
        check("abort_no_done", {29'd0, done, x_valid, load_ready}, 32'b001);

        // Abort beats a simultaneous request in IDLE.
        abort      = 1'b1;
        load_valid = 1'b1;
        data_in    = 8'hFF;
        step();
        abort      = 1'b0;
        load_valid = 1'b0;
        check("abort_wins_idle", {28'd0, busy, x_valid, state_out}, 32'd0);
        step();
        check("abort_wins_idle_next", {28'd0, busy, x_valid, state_out}, 32'd0);

        // Reset while in the inter-frame gap.
        data_in    = 8'hF5;
        nbits_in   = 4'd3;
        repeat_in  = 4'd2;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        step();
        step();
        step();
        check("gap_state", {28'd0, x_valid, x_out, state_out}, 32'b0010);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("reset_in_gap", {26'd0, x_out, x_valid, done, busy, state_out}, 32'd0);
        run_frame(8'h01, 1, 1, 1'b0, nv, dc);
        check("post_reset_nvalid", nv, 1);
        check("post_reset_done_cycle", dc, 2);

        // Randomized frames with request noise while busy.
        for (int k = 0; k < 25; k++) begin
            int idle;
            idle = $urandom_range(0, 2);
            for (int j = 0; j < idle; j++) step();
            run_frame(8'($urandom), $urandom_range(0, 15), $urandom_range(0, 5), 1'b1, nv, dc);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

endmodule
